// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - load-use/branch/memory-wait stall sequencer for the 5-stage pipeline
// Optional stall statistics counter: define STALL_STATS_EN.
module pipeline_stall_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_write,
  output logic                  idex_bubble,
  output logic                  exmem_write,
  output logic                  memwb_bubble,
  output logic                  mem_timeout,
  output logic [31:0]           stall_cycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       load_use;
  logic       freeze;

  assign load_use = idex_mem_read && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  // A wait that completes this cycle lets the pipeline advance with normal RUN decisions.
  assign freeze = (state == ERROR) ||
                  ((state == MEM_WAIT) && !mem_ready) ||
                  ((state == RUN) && mem_req && !mem_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == MAX_WAIT_C) begin
              state       <= ERROR;
              mem_timeout <= 1'b1;
            end
          end
        end
        default: begin
          state       <= ERROR;
          mem_timeout <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    memwb_bubble = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (freeze) begin
      // Frozen registers hold; only MEM/WB gets a bubble so the stuck access never writes back twice.
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
    end
  end

`ifdef STALL_STATS_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (!pc_write && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - randomized self-checking bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

  localparam int RW = 5;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          idex_mem_read;
  logic [RW-1:0] idex_rt, ifid_rs, ifid_rt;
  logic          branch_taken, mem_req, mem_ready;
  logic          pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic          exmem_write, memwb_bubble, mem_timeout;
  logic [31:0]   stall_cycles;

  pipeline_stall_controller #(.REG_ADDR_W(RW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_write(exmem_write),
    .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [39:0] obs;
  assign obs = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                exmem_write, memwb_bubble, mem_timeout, stall_cycles};

  // Reference model: count of consecutive unfinished-access cycles, sticky error, stall tally.
  int          m_busy = 0, n_busy = 0;
  bit          m_dead = 0, n_dead = 0;
  logic [31:0] m_stat = 0, n_stat = 0;
  logic [39:0] exp_v;

  task automatic apply(input bit r, input bit mr, input int irt, input int rs, input int rt,
                       input bit br, input bit mq, input bit rdy);
    bit pcw, ifw, ifl, idw, idb, exw, mwb, lu, frz;
    @(negedge clk);
    m_busy = n_busy; m_dead = n_dead; m_stat = n_stat;
    rst = r; idex_mem_read = mr; idex_rt = RW'(irt); ifid_rs = RW'(rs); ifid_rt = RW'(rt);
    branch_taken = br; mem_req = mq; mem_ready = rdy;
    #1;
    pcw = 1; ifw = 1; ifl = 0; idw = 1; idb = 0; exw = 1; mwb = 0;
    n_busy = m_busy; n_dead = m_dead; n_stat = m_stat;
    lu = mr && (irt != 0) && (irt == rs || irt == rt);
    if (r) begin
      pcw = 0; ifw = 0; ifl = 1; idb = 1; mwb = 1;
      n_busy = 0; n_dead = 0; n_stat = 0;
    end else begin
      frz = m_dead || (m_busy > 0 ? !rdy : (mq && !rdy));
      if (frz) begin
        pcw = 0; ifw = 0; idw = 0; exw = 0; mwb = 1;
        if (!m_dead) begin
          n_busy = m_busy + 1;
          n_dead = (n_busy > MW);
        end
      end else begin
        n_busy = 0;
        if (lu) begin pcw = 0; ifw = 0; idb = 1; end
        else if (br) ifl = 1;
      end
      if (!pcw && m_stat != 32'hFFFF_FFFF) n_stat = m_stat + 1;
    end
`ifdef STALL_STATS_EN
    exp_v = {pcw, ifw, ifl, idw, idb, exw, mwb, m_dead, m_stat};
`else
    exp_v = {pcw, ifw, ifl, idw, idb, exw, mwb, m_dead, 32'd0};
`endif
  endtask

  task automatic test_reset();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (obs[39:33] !== exp_v[39:33]) begin
      fails++; $display("FAIL reset_outputs got=%b want=%b", obs[39:33], exp_v[39:33]);
    end
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL reset_idle got=%h want=%h", obs, exp_v); end
    end
  endtask

  task automatic test_load_use();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 1, 8, 8, 3, 0, 0, 0);
    tests++;
    if (obs !== exp_v || idex_bubble !== 1'b1) begin
      fails++; $display("FAIL load_use_rs got=%h want=%h", obs, exp_v);
    end
    apply(0, 0, 8, 8, 3, 0, 0, 0);
    tests++;
    if (obs !== exp_v || pc_write !== 1'b1) begin
      fails++; $display("FAIL load_use_release got=%h want=%h", obs, exp_v);
    end
    apply(0, 1, 9, 2, 9, 0, 0, 0);
    tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL load_use_rt got=%h want=%h", obs, exp_v); end
    apply(0, 1, 0, 0, 0, 0, 0, 0);
    tests++;
    if (obs !== exp_v || pc_write !== 1'b1) begin
      fails++; $display("FAIL load_use_r0 got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_branch_hazard();
    apply(0, 1, 5, 5, 0, 1, 0, 0);
    tests++;
    if (obs !== exp_v || ifid_flush !== 1'b0) begin
      fails++; $display("FAIL branch_with_lu got=%h want=%h", obs, exp_v);
    end
    apply(0, 0, 5, 5, 0, 1, 0, 0);
    tests++;
    if (obs !== exp_v || ifid_flush !== 1'b1 || pc_write !== 1'b1) begin
      fails++; $display("FAIL branch_flush got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_mem_wait();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 0, 1, 0);
      tests++;
      if (obs !== exp_v || memwb_bubble !== 1'b1) begin
        fails++; $display("FAIL mem_wait_freeze%0d got=%h want=%h", i, obs, exp_v);
      end
    end
    apply(0, 0, 0, 0, 0, 1, 1, 1);
    tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL mem_wait_done got=%h want=%h", obs, exp_v); end
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL mem_wait_after got=%h want=%h", obs, exp_v); end
`ifdef STALL_STATS_EN
    tests++;
    if (stall_cycles !== 32'd3) begin
      fails++; $display("FAIL mem_wait_stats got=%0d want=3", stall_cycles);
    end
`endif
  endtask

  task automatic test_timeout();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < MW + 4; i++) begin
      apply(0, 0, 0, 0, 0, 0, 1, (i > MW) ? 1'b1 : 1'b0);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL timeout_c%0d got=%h want=%h", i, obs, exp_v); end
    end
    tests++;
    if (mem_timeout !== 1'b1 || pc_write !== 1'b0) begin
      fails++; $display("FAIL timeout_sticky got=%b want=1", mem_timeout);
    end
    apply(1, 0, 0, 0, 0, 0, 1, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (obs !== exp_v || mem_timeout !== 1'b0) begin
      fails++; $display("FAIL timeout_clear got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid_wait();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 1, 0);
    apply(1, 0, 0, 0, 0, 0, 1, 0);
    tests++;
    if (obs[39:33] !== 7'b0011111) begin
      fails++; $display("FAIL midwait_reset got=%b want=%b", obs[39:33], 7'b0011111);
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (obs !== exp_v || pc_write !== 1'b1) begin
      fails++; $display("FAIL midwait_run got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_random();
    int rdy_pct;
    for (int i = 0; i < 800; i++) begin
      rdy_pct = (i < 400) ? 50 : 15;
      apply(($urandom_range(0, 59) == 0), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 1), ($urandom_range(0, 99) < rdy_pct));
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL random_c%0d got=%h want=%h", i, obs, exp_v); end
    end
  endtask

  initial begin
    rst = 1; idex_mem_read = 0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
    test_reset();
    test_load_use();
    test_branch_hazard();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Hazard and stall sequencer for the 5-stage MIPS pipeline. It detects load-use hazards and stalls IF/ID while injecting an ID/EX bubble. It flushes IF/ID on taken branches. It freezes the whole pipeline during multi-cycle data-memory accesses, and zeroes the WB_control fed into the MEM/WB register so no duplicate register write occurs. A watchdog flags memory accesses that never complete.

Parameters:
REG_ADDR_W, 5, register-specifier width
MAX_WAIT, 15, max consecutive MEM_WAIT cycles before timeout (1..255)

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  synchronous reset, active-high
idex_mem_read  input  1  ID/EX instruction is a load
idex_rt  input  REG_ADDR_W  load destination in ID/EX
ifid_rs  input  REG_ADDR_W  rs of instruction in IF/ID
ifid_rt  input  REG_ADDR_W  rt of instruction in IF/ID
branch_taken  input  1  branch resolved taken in ID
mem_req  input  1  EX/MEM holds load or store
mem_ready  input  1  data memory completes access this cycle
pc_write  output  1  PC update enable
ifid_write  output  1  IF/ID load enable
ifid_flush  output  1  IF/ID clear to NOP
idex_write  output  1  ID/EX load enable
idex_bubble  output  1  zero ID/EX control fields
exmem_write  output  1  EX/MEM load enable
memwb_bubble  output  1  force WB_control=2'b00 into MEM/WB
mem_timeout  output  1  sticky watchdog error
stall_cycles  output  32  stall statistic (see Optional Feature)

Behaviour:
- Decision on 1-cycle reset: clk/rst only; rst is sampled at the rising edge.
- Registered state: state {RUN, MEM_WAIT, ERROR}, wait_cnt (8 bit), mem_timeout. All other outputs are combinational from the state and inputs.
- rst=1 on an edge sets state=RUN, wait_cnt=0, mem_timeout=0.
- While rst is high, outputs are: pc_write=0, ifid_write=0, ifid_flush=1, idex_write=1, idex_bubble=1, exmem_write=1, memwb_bubble=1.
- Load-use hazard: lu = idex_mem_read & (idex_rt!=0) & (idex_rt==ifid_rs | idex_rt==ifid_rt). Register $0 never causes a hazard.
- RUN, default: all write enables=1; flush and bubble outputs=0.
- RUN, mem_req & ~mem_ready (highest priority):
  - freeze: pc_write=ifid_write=idex_write=exmem_write=0, memwb_bubble=1, ifid_flush=0, idex_bubble=0.
  - next state=MEM_WAIT, wait_cnt=1.
- RUN, else if lu: pc_write=0, ifid_write=0, idex_bubble=1; branch_taken is ignored this cycle (re-evaluated next cycle). Latency is exactly 1 stall cycle per hazard.
- RUN, else if branch_taken: ifid_flush=1; PC still writes the target.
- RUN, mem_req & mem_ready in the same cycle: no stall.
- MEM_WAIT, mem_ready=0: freeze outputs as above; wait_cnt++. When wait_cnt==MAX_WAIT, next state=ERROR.
- MEM_WAIT, mem_ready=1: outputs take RUN values for this cycle, with lu and branch_taken evaluated normally. The access completes and the pipeline advances. Next state=RUN, wait_cnt=0.
- ERROR: freeze outputs permanently; mem_timeout=1. Exit only via rst.
- A reset asserted during MEM_WAIT or ERROR takes effect on the next edge. Any pending access is abandoned.
- Freeze cycles never assert ifid_flush or idex_bubble, so frozen registers keep their contents.

Optional Feature:
Macro STALL_STATS_EN.
- Defined: stall_cycles is a 32-bit counter, reset to 0 by rst. It increments every non-reset cycle with pc_write=0 and saturates at 32'hFFFFFFFF.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Load-use: idex_mem_read=1, idex_rt=8, ifid_rs=8 for 1 cycle -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle only; same case with idex_rt=0 -> no stall.
- Branch plus hazard: branch_taken=1 together with lu -> ifid_flush=0, stall; next cycle lu=0, branch_taken=1 -> ifid_flush=1, pc_write=1.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> 3 freeze cycles with memwb_bubble=1, then a RUN-value cycle, then state RUN; with STALL_STATS_EN, stall_cycles=3.
- Timeout: MAX_WAIT=4, mem_req=1, mem_ready held 0 -> mem_timeout=1 after the 5th freeze cycle, stays frozen; rst=1 for 1 cycle -> mem_timeout=0, RUN.
- Reset mid-wait: rst asserted in the 2nd MEM_WAIT cycle -> next cycle state=RUN, wait_cnt=0; reset-cycle outputs are ifid_flush=1, idex_bubble=1, memwb_bubble=1, pc_write=0.
